// File: rtl/usb_rx_decoder.sv
// USB receive bit-level front end: NRZI decode, bit unstuffing, SYNC hunt,
// PID assembly and check, data byte deserialisation and EOP detection.
// All outputs are registered; pulses are high for the clk cycle following
// the posedge on which the completing bit sample was taken.
module usb_rx_decoder #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  logic       rx_en,
  input  logic       dp,
  input  logic       dm,
  output logic       valid_sync,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic       pid_err,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       eop,
  output logic       stuff_err,
  output logic       align_err
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int SE0_W  = $clog2(EOP_SE0_BITS + 2);

  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
  localparam logic [SE0_W-1:0]  SE0_MIN   = SE0_W'(EOP_SE0_BITS);
  localparam logic [SE0_W-1:0]  SE0_LIMIT = SE0_W'(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HUNT = 3'd1,
    PID  = 3'd2,
    DATA = 3'd3,
    EOP  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic               prev_j, prev_n;        // previous J/K line state, 1 = J
  logic [7:0]         hist, hist_n;          // decoded-bit history while hunting
  logic [2:0]         hist_cnt, hist_cnt_n;  // bits seen in HUNT, saturates at 7
  logic [ONES_W-1:0]  ones, ones_n;
  logic [7:0]         shreg, shreg_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [SE0_W-1:0]   se0_cnt, se0_n;
  logic [3:0]         pid_n;
  logic [7:0]         data_n;
  logic               sync_n, pid_valid_n, pid_err_n, byte_valid_n;
  logic               eop_n, stuff_err_n, align_err_n;

  logic               line_se0;
  logic               dec_bit;
  logic               fwd;
  logic               go_hunt;
  logic [7:0]         sh;

  // SE1 is folded into SE0; otherwise dp alone tells J from K
  assign line_se0 = (dp == dm);
  assign dec_bit  = (dp == prev_j);

  // PID byte is valid when the upper nibble is the complement of the lower
  function automatic logic pid_ok(input logic [7:0] b);
    return (b[7:4] == ~b[3:0]);
  endfunction

  // Next-state logic for the whole receive path, one step per bit strobe
  always_comb begin
    state_n      = state;
    prev_n       = prev_j;
    hist_n       = hist;
    hist_cnt_n   = hist_cnt;
    ones_n       = ones;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    se0_n        = se0_cnt;
    pid_n        = pid;
    data_n       = data;
    sync_n       = 1'b0;
    pid_valid_n  = 1'b0;
    pid_err_n    = 1'b0;
    byte_valid_n = 1'b0;
    eop_n        = 1'b0;
    stuff_err_n  = 1'b0;
    align_err_n  = 1'b0;
    fwd          = 1'b0;
    go_hunt      = 1'b0;
    sh           = shreg;

    if (!rx_en) begin
      state_n    = IDLE;
      prev_n     = 1'b1;
      hist_n     = '0;
      hist_cnt_n = '0;
      ones_n     = '0;
      shreg_n    = '0;
      bit_cnt_n  = '0;
      se0_n      = '0;
    end else if (sample) begin
      unique case (state)
        IDLE: state_n = HUNT;
        HUNT: begin
          if (!line_se0) begin
            prev_n = dp;
            hist_n = {hist[6:0], dec_bit};
            if (hist_cnt != 3'd7) hist_cnt_n = hist_cnt + 3'd1;
            if (hist_cnt == 3'd7 && hist_n == 8'h01) begin
              sync_n    = 1'b1;
              state_n   = PID;
              ones_n    = '0;
              shreg_n   = '0;
              bit_cnt_n = '0;
            end
          end
        end
        PID, DATA: begin
          if (line_se0) begin
            if (state == PID) begin
              pid_err_n = 1'b1;
              go_hunt   = 1'b1;
            end else begin
              state_n = EOP;
              se0_n   = SE0_W'(1);
            end
          end else begin
            prev_n = dp;
            if (ones == STUFF_MAX) begin
              // this bit must be a stuffed 0 and is never forwarded
              if (dec_bit) begin
                stuff_err_n = 1'b1;
                go_hunt     = 1'b1;
              end else begin
                ones_n = '0;
              end
            end else begin
              ones_n = dec_bit ? ones + ONES_W'(1) : '0;
              fwd    = 1'b1;
            end
          end
        end
        EOP: begin
          if (line_se0) begin
            if (se0_cnt == SE0_LIMIT) go_hunt = 1'b1;
            else                      se0_n   = se0_cnt + SE0_W'(1);
          end else if (dp && se0_cnt >= SE0_MIN) begin
            eop_n       = 1'b1;
            align_err_n = (bit_cnt != 3'd0);
            go_hunt     = 1'b1;
          end else begin
            go_hunt = 1'b1;
          end
        end
        default: go_hunt = 1'b1;
      endcase

      if (fwd) begin
        sh        = {dec_bit, shreg[7:1]};
        shreg_n   = sh;
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (state == PID) begin
            if (pid_ok(sh)) begin
              pid_n       = sh[3:0];
              pid_valid_n = 1'b1;
              state_n     = DATA;
              shreg_n     = '0;
              bit_cnt_n   = '0;
            end else begin
              pid_err_n = 1'b1;
              go_hunt   = 1'b1;
            end
          end else begin
            data_n       = sh;
            byte_valid_n = 1'b1;
          end
        end
      end

      if (go_hunt) begin
        state_n    = HUNT;
        prev_n     = 1'b1;
        hist_n     = '0;
        hist_cnt_n = '0;
        ones_n     = '0;
        shreg_n    = '0;
        bit_cnt_n  = '0;
        se0_n      = '0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_j     <= 1'b1;
      hist       <= '0;
      hist_cnt   <= '0;
      ones       <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      se0_cnt    <= '0;
      pid        <= '0;
      data       <= '0;
      valid_sync <= 1'b0;
      pid_valid  <= 1'b0;
      pid_err    <= 1'b0;
      byte_valid <= 1'b0;
      eop        <= 1'b0;
      stuff_err  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state      <= state_n;
      prev_j     <= prev_n;
      hist       <= hist_n;
      hist_cnt   <= hist_cnt_n;
      ones       <= ones_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      se0_cnt    <= se0_n;
      pid        <= pid_n;
      data       <= data_n;
      valid_sync <= sync_n;
      pid_valid  <= pid_valid_n;
      pid_err    <= pid_err_n;
      byte_valid <= byte_valid_n;
      eop        <= eop_n;
      stuff_err  <= stuff_err_n;
      align_err  <= align_err_n;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Scoreboard bench for usb_rx_decoder: directed packets are NRZI-encoded
// on the fly, expected output events are queued before each packet and a
// free-running monitor pops and compares on every output pulse.
module tb_usb_rx_decoder;

  localparam int K_SYNC = 0;
  localparam int K_PIDV = 1;
  localparam int K_PERR = 2;
  localparam int K_BYTE = 3;
  localparam int K_STUF = 4;
  localparam int K_EOP  = 5;
  localparam int K_ALGN = 6;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample = 1'b0;
  logic       rx_en = 1'b0;
  logic       dp = 1'b1;
  logic       dm = 1'b0;
  logic       valid_sync, pid_valid, pid_err, byte_valid, eop, stuff_err, align_err;
  logic [3:0] pid;
  logic [7:0] data;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic tx_j = 1'b1;

  usb_rx_decoder #(.STUFF_LEN(6), .EOP_SE0_BITS(2)) dut (
    .clk(clk), .rst(rst), .sample(sample), .rx_en(rx_en), .dp(dp), .dm(dm),
    .valid_sync(valid_sync), .pid(pid), .pid_valid(pid_valid), .pid_err(pid_err),
    .data(data), .byte_valid(byte_valid), .eop(eop), .stuff_err(stuff_err),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [7:0] val, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got val=%02h, no event expected", name, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        failures++;
        $display("FAIL evt_%s: got kind=%0d val=%02h, required kind=%0d val=%02h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %02h, required %02h", name, got, req);
    end
  endtask

  // Monitor: every output pulse consumes the next expected event
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_sync) check_evt(K_SYNC, 8'h00, "valid_sync");
      if (pid_valid)  check_evt(K_PIDV, {4'h0, pid}, "pid_valid");
      if (pid_err)    check_evt(K_PERR, {4'h0, pid}, "pid_err");
      if (byte_valid) check_evt(K_BYTE, data, "byte_valid");
      if (stuff_err)  check_evt(K_STUF, 8'h00, "stuff_err");
      if (eop)        check_evt(K_EOP, 8'h00, "eop");
      if (align_err)  check_evt(K_ALGN, 8'h00, "align_err");
    end
  end

  task automatic line(input logic p, input logic m);
    @(posedge clk);
    #1;
    dp = p;
    dm = m;
    sample = 1'b1;
    @(posedge clk);
    #1;
    sample = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) tx_j = ~tx_j;
    line(tx_j, ~tx_j);
  endtask

  task automatic idle_j(input int n);
    tx_j = 1'b1;
    repeat (n) line(1'b1, 1'b0);
  endtask

  task automatic send_sync();
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_eop();
    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    idle_j(1);
  endtask

  task automatic ack_packet();
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h02);
    push(K_EOP, 8'h00);
    idle_j(4);
    send_sync();
    send_byte(8'hD2);
    send_eop();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("reset_pid", {4'h0, pid}, 8'h00);
    check_val("reset_data", data, 8'h00);
    check_val("reset_pulses",
              {1'b0, valid_sync, pid_valid, pid_err, byte_valid, eop, stuff_err, align_err},
              8'h00);
    rx_en = 1'b1;

    // ACK handshake
    ack_packet();

    // NAK handshake
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h0A);
    push(K_EOP, 8'h00);
    idle_j(4);
    send_sync();
    send_byte(8'h5A);
    send_eop();

    // bad check nibble; pid keeps NAK value, then a clean ACK
    push(K_SYNC, 8'h00);
    push(K_PERR, 8'h0A);
    idle_j(4);
    send_sync();
    send_byte(8'h22);
    ack_packet();

    // DATA0 with 0xFF; PID ends in two 1s, so a stuffed 0 follows 4 data 1s
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h03);
    push(K_BYTE, 8'hFF);
    push(K_EOP, 8'h00);
    idle_j(4);
    send_sync();
    send_byte(8'hC3);
    repeat (4) send_bit(1'b1);
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    send_eop();

    // stuffed bit sent as 1
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h03);
    push(K_STUF, 8'h00);
    idle_j(4);
    send_sync();
    send_byte(8'hC3);
    repeat (5) send_bit(1'b1);
    send_eop();

    // EOP after a partial byte
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h03);
    push(K_EOP, 8'h00);
    push(K_ALGN, 8'h00);
    idle_j(4);
    send_sync();
    send_byte(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_eop();

    // rx_en dropped after 3 data bits
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h03);
    idle_j(4);
    send_sync();
    send_byte(8'hC3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(posedge clk);
    #1 rx_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("rxen_pid_hold", {4'h0, pid}, 8'h03);
    check_val("rxen_data_hold", data, 8'hFF);
    rx_en = 1'b1;
    ack_packet();

    // reset asserted after 3 data bits
    push(K_SYNC, 8'h00);
    push(K_PIDV, 8'h03);
    idle_j(4);
    send_sync();
    send_byte(8'hC3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_pid", {4'h0, pid}, 8'h00);
    check_val("rst_data", data, 8'h00);
    repeat (4) @(posedge clk);
    ack_packet();

    repeat (20) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
Receive-side bit-level front end for the USB host/device link. It samples the D+/D- line once per bit strobe, then:
- performs NRZI decode and bit unstuffing;
- detects SYNC, assembles and checks the PID, and deserialises data bytes;
- detects EOP.
It feeds the handshake/data receive FSMs directly: they consume valid_sync, pid, pid_valid, byte_valid, eop and the error pulses. Timeout counting stays in those consumers.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which one stuffed 0 is expected and discarded
EOP_SE0_BITS, 2, number of SE0 bit times required before J to recognise EOP

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  reset; one clock, reset is synchronous and active-high
sample  input  1  one-cycle strobe per USB bit time; logic advances only when high
rx_en  input  1  decoder enabled; low forces IDLE and clears all state except outputs' reset values
dp  input  1  D+ line, already synchronised
dm  input  1  D- line, already synchronised
valid_sync  output  1  one-cycle pulse: SYNC recognised
pid  output  4  last accepted PID, held until next pid_valid
pid_valid  output  1  one-cycle pulse: PID received and check nibble correct
pid_err  output  1  one-cycle pulse: PID check nibble mismatch, or SE0 before 8 PID bits
data  output  8  last assembled byte, held until next byte_valid
byte_valid  output  1  one-cycle pulse: new data byte
eop  output  1  one-cycle pulse: EOP recognised
stuff_err  output  1  one-cycle pulse: decoded 1 where a stuffed 0 was required
align_err  output  1  one-cycle pulse: EOP with a partial byte in the DATA state

Behaviour:
- Reset (rst high at posedge): state IDLE; all pulse outputs 0; pid=0; data=0; prev line state = J; all counters and shift registers 0. Reset mid-packet discards the packet silently, with no error pulse.
- Line states: J = dp1/dm0, K = dp0/dm1, SE0 = 0/0, SE1 = 1/1. SE1 is treated as SE0.
- NRZI: on each sample with J or K, the decoded bit is 1 if the state equals prev, else 0. prev is then updated to the current state. SE0 does not update prev. prev resets to J on rst, on rx_en low, and on return to HUNT.
- Unstuffing: a ones counter increments on decoded 1 and clears on decoded 0.
  - When it equals STUFF_LEN, the next decoded bit is checked and dropped.
  - If that bit is 0, the counter clears and nothing is forwarded.
  - If that bit is 1, stuff_err pulses and the FSM goes to HUNT.
  - Unstuffing is active in PID and DATA only.
- FSM states: IDLE, HUNT, PID, DATA, EOP.
  - IDLE: rx_en=1 goes to HUNT.
  - HUNT: 8-bit history of decoded bits. When the last 8 bits in arrival order are 0,0,0,0,0,0,0,1 (KJKJKJKK), pulse valid_sync and go to PID. SE0 in HUNT is ignored.
  - PID: shift 8 bits LSB first.
    - After the 8th bit: if bits[7:4] == ~bits[3:0], load pid = bits[3:0], pulse pid_valid, go to DATA.
    - Otherwise pulse pid_err and go to HUNT.
    - SE0 before the 8th bit: pulse pid_err, go to HUNT.
  - DATA: shift bits LSB first. Every 8th forwarded bit loads data and pulses byte_valid. The bit counter wraps 7 to 0. The first SE0 goes to EOP.
  - EOP: count SE0 samples, including the one that entered.
    - When the count reaches EOP_SE0_BITS and the next sample is J: pulse eop; also pulse align_err if the DATA bit counter is nonzero; go to HUNT.
    - K, or more than EOP_SE0_BITS+1 SE0 samples: go to HUNT with no eop pulse.
- Handshake packets (ACK/NAK/STALL): DATA is entered with zero bytes, and the EOP is the next event.
- Latency: every output pulse is registered. It is high for exactly the clk cycle after the posedge on which the completing sample was taken. Only one pulse per output per sample.
- rx_en low: synchronously forces IDLE on the next posedge, clears the counters and prev=J, and emits no pulses. pid and data hold their values.
- sample low: all state holds and all pulses are 0.
- Simultaneous events:
  - A stuff violation on the bit that would complete a byte gives stuff_err only, no byte_valid.
  - rst has priority over rx_en, and rx_en over sample.

Test Plan:
- SYNC then ACK PID 0xD2 (LSB first) then SE0,SE0,J → valid_sync, then pid_valid with pid=4'b0010, then eop, with align_err=0 and no byte_valid.
- SYNC then NAK 0x5A then EOP → pid=4'b1010, pid_valid, eop.
- SYNC then PID byte 0x22 (bad check nibble) → pid_err pulse, no pid_valid, pid holds its previous value, decoder re-hunts and accepts a following SYNC+ACK.
- SYNC, DATA0 PID 0xC3, byte 0xFF with a stuffed 0 inserted after six 1s, then EOP → byte_valid with data=0xFF exactly once, eop, no stuff_err.
- Same as above but the stuffed bit is sent as 1 → stuff_err pulse, no byte_valid, no eop.
- rst asserted, or rx_en dropped, mid-DATA after 3 bits of a byte → no pulses, state IDLE. Then a full SYNC+ACK+EOP after re-enable decodes correctly.
